// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: DATA register feeds a small byte FIFO,
// STATUS register reports FSM/FIFO state and a sticky overflow flag.
module mmio_uart_tx #(
   parameter logic [31:0] BASE_ADDR    = 32'h0040_0000,
   parameter int          CLKS_PER_BIT = 16,
   parameter int          FIFO_DEPTH   = 4
) (
   input  logic        clk,
   input  logic        RESET,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wmask,
   input  logic        mem_rstrb,
   output logic [31:0] mem_rdata,
   output logic        sel,
   output logic        uart_txd,
   output logic        tx_irq
);

   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   logic [7:0]        fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
   logic [CNT_W-1:0]  count_reg;
   logic              overflow_reg;
   state_t            state_reg, state_next;
   logic [BAUD_W-1:0] baud_reg, baud_next;
   logic [2:0]        bit_reg, bit_next;
   logic [7:0]        shift_reg, shift_next;
   logic              txd_reg, txd_next;
   logic [31:0]       rdata_reg;

   logic        wr_en, data_wr, stat_wr, fifo_empty, fifo_full, baud_done;
   logic        pop, push;
   logic [31:0] status_word;

   assign sel        = (mem_addr[31:3] == BASE_ADDR[31:3]);
   assign wr_en      = sel && mem_wmask[0];
   assign data_wr    = wr_en && !mem_addr[2];
   assign stat_wr    = wr_en && mem_addr[2];
   assign fifo_empty = (count_reg == '0);
   assign fifo_full  = (count_reg == DEPTH_CNT);
   assign baud_done  = (baud_reg == BAUD_LAST);
   // A full FIFO still takes a byte when the transmitter pops in the same cycle.
   assign push       = data_wr && (!fifo_full || pop);

   assign status_word = {23'd0, 5'(count_reg), overflow_reg, fifo_empty, fifo_full,
                         state_reg != IDLE};

   assign mem_rdata = rdata_reg;
   assign uart_txd  = txd_reg;
   assign tx_irq    = fifo_empty && (state_reg == IDLE);

   always_comb begin
      state_next = state_reg;
      baud_next  = baud_reg;
      bit_next   = bit_reg;
      shift_next = shift_reg;
      pop        = 1'b0;
      txd_next   = 1'b1;
      case (state_reg)
         IDLE: begin
            if (!fifo_empty) begin
               pop        = 1'b1;
               shift_next = fifo_mem[rd_ptr_reg];
               baud_next  = '0;
               state_next = START;
            end
         end
         START: begin
            txd_next = 1'b0;
            if (baud_done) begin
               baud_next  = '0;
               bit_next   = 3'd0;
               state_next = DATA;
            end else begin
               baud_next = baud_reg + BAUD_W'(1);
            end
         end
         DATA: begin
            txd_next = shift_reg[0];
            if (baud_done) begin
               baud_next  = '0;
               shift_next = shift_reg >> 1;
               if (bit_reg == 3'd7) begin
                  state_next = STOP;
               end else begin
                  bit_next = bit_reg + 3'd1;
               end
            end else begin
               baud_next = baud_reg + BAUD_W'(1);
            end
         end
         STOP: begin
            if (baud_done) begin
               baud_next = '0;
               // Chain straight into the next frame so back-to-back bytes have no idle gap.
               if (!fifo_empty) begin
                  pop        = 1'b1;
                  shift_next = fifo_mem[rd_ptr_reg];
                  state_next = START;
               end else begin
                  state_next = IDLE;
               end
            end else begin
               baud_next = baud_reg + BAUD_W'(1);
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         state_reg    <= IDLE;
         baud_reg     <= '0;
         bit_reg      <= 3'd0;
         shift_reg    <= 8'd0;
         txd_reg      <= 1'b1;
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         overflow_reg <= 1'b0;
         rdata_reg    <= 32'd0;
      end else begin
         state_reg <= state_next;
         baud_reg  <= baud_next;
         bit_reg   <= bit_next;
         shift_reg <= shift_next;
         txd_reg   <= txd_next;
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         end
         count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
         if (data_wr && !push) begin
            overflow_reg <= 1'b1;
         end else if (stat_wr && mem_wdata[3]) begin
            overflow_reg <= 1'b0;
         end
         if (sel && mem_rstrb) begin
            rdata_reg <= mem_addr[2] ? status_word : 32'd0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_reg] <= mem_wdata[7:0];
      end
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: expected serial bytes are queued as they are
// written and checked by a line monitor as frames appear on uart_txd.
module tb_mmio_uart_tx;

   localparam logic [31:0] BASE = 32'h0040_0000;
   localparam int CPB = 4;
   localparam int FRAME = 10 * CPB;

   logic        clk;
   logic        RESET;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wmask;
   logic        mem_rstrb, sel, uart_txd, tx_irq;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   bit rst_seen = 0;
   logic [7:0] exp_q[$];
   int starts[$];

   mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
      .clk(clk), .RESET(RESET), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wmask(mem_wmask), .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata),
      .sel(sel), .uart_txd(uart_txd), .tx_irq(tx_irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;
   always @(posedge RESET) rst_seen = 1'b1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
      mem_addr = a; mem_wdata = d; mem_wmask = m; mem_rstrb = 1'b0;
      @(posedge clk); #1;
      mem_wmask = 4'b0000;
   endtask

   task automatic send(input logic [7:0] b, input bit accepted);
      wr(BASE, {24'd0, b}, 4'b0001);
      if (accepted) exp_q.push_back(b);
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] v);
      mem_addr = a; mem_rstrb = 1'b1; mem_wmask = 4'b0000;
      @(posedge clk); #1;
      mem_rstrb = 1'b0;
      v = mem_rdata;
   endtask

   task automatic wait_cyc(input int target);
      while (cyc < target) begin
         @(posedge clk); #1;
      end
   endtask

   // Line monitor: samples each bit mid-cell, drops any frame cut by a reset.
   initial begin
      logic [7:0] d;
      logic sb, stb;
      int sc;
      forever begin
         @(negedge uart_txd);
         #1;
         sc = cyc;
         rst_seen = 1'b0;
         repeat (2) @(negedge clk);
         sb = uart_txd;
         for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            d[i] = uart_txd;
         end
         repeat (CPB) @(negedge clk);
         stb = uart_txd;
         if (!rst_seen) begin
            starts.push_back(sc);
            check("start_bit", {31'd0, sb}, 32'd0);
            check("stop_bit", {31'd0, stb}, 32'd1);
            check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("rx_byte", {24'd0, d}, {24'd0, exp_q.pop_front()});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] v;
      int wc;
      RESET = 1'b1; mem_addr = BASE; mem_wdata = 32'd0; mem_wmask = 4'b0000; mem_rstrb = 1'b0;
      #1;
      check("reset_txd", {31'd0, uart_txd}, 32'd1);
      check("reset_irq", {31'd0, tx_irq}, 32'd1);
      check("reset_rdata", mem_rdata, 32'd0);
      repeat (2) @(posedge clk); #1;
      RESET = 1'b0;
      check("sel_base", {31'd0, sel}, 32'd1);
      mem_addr = BASE + 32'd8; #1;
      check("sel_outside", {31'd0, sel}, 32'd0);
      rd(BASE + 32'd4, v); check("reset_status", v, 32'h4);
      rd(BASE, v);         check("data_read_zero", v, 32'h0);

      // Single byte 0xA5: start 2 cycles after the write edge, 4 cycles long
      starts.delete();
      send(8'hA5, 1'b1); wc = cyc;
      wait_cyc(wc + 5);  check("t2_start_last_cycle", {31'd0, uart_txd}, 32'd0);
      wait_cyc(wc + 6);  check("t2_bit0", {31'd0, uart_txd}, 32'd1);
      check("t2_irq_busy", {31'd0, tx_irq}, 32'd0);
      wait_cyc(wc + 43); check("t2_irq_done", {31'd0, tx_irq}, 32'd1);
      check("t2_start_cycle", 32'(starts.size() > 0 ? starts[$] - wc : -1), 32'd2);

      // Five back-to-back bytes while idle: all fit because the first pops at once
      starts.delete();
      for (int i = 0; i < 5; i++) send(8'h11 + 8'(i), 1'b1);
      rd(BASE + 32'd4, v); check("t3_status", v, 32'h43);
      wait_cyc(cyc + 5 * FRAME + 20);
      check("t3_frames", 32'(starts.size()), 32'd5);
      for (int i = 0; i + 1 < starts.size(); i++)
         check("t3_gap", 32'(starts[i+1] - starts[i]), FRAME);
      check("t3_irq", {31'd0, tx_irq}, 32'd1);

      // Overflow during a frame, then read and clear in the same cycle
      starts.delete();
      send(8'h21, 1'b1);
      repeat (5) @(posedge clk); #1;
      for (int i = 0; i < 6; i++) send(8'h22 + 8'(i), i < 4);
      // transmitter still busy, so tx_active is set alongside full/overflow/count 4
      rd(BASE + 32'd4, v); check("t4_status_ovf", v, 32'h4B);
      mem_addr = BASE + 32'd4; mem_wdata = 32'h8; mem_wmask = 4'b0001; mem_rstrb = 1'b1;
      @(posedge clk); #1;
      mem_wmask = 4'b0000; mem_rstrb = 1'b0;
      check("t4_read_prewrite", mem_rdata, 32'h4B);
      rd(BASE + 32'd4, v); check("t4_status_cleared", v, 32'h43);
      wait_cyc(cyc + 5 * FRAME + 20);
      check("t4_frames", 32'(starts.size()), 32'd5);
      check("t4_queue_empty", 32'(exp_q.size()), 32'd0);

      // Read strobe and DATA write in the same cycle
      rd(BASE + 32'd4, v); check("t5_status_before", v, 32'h4);
      mem_addr = BASE; mem_wdata = 32'h5A; mem_wmask = 4'b0001; mem_rstrb = 1'b1;
      @(posedge clk); #1;
      mem_wmask = 4'b0000; mem_rstrb = 1'b0;
      exp_q.push_back(8'h5A);
      check("t5_data_read", mem_rdata, 32'h0);
      wait_cyc(cyc + FRAME + 10);
      check("t5_sent", 32'(exp_q.size()), 32'd0);

      // Writes that must be ignored
      rd(BASE + 32'd4, v); check("t6_status_before", v, 32'h4);
      wr(BASE + 32'd8, 32'h77, 4'b0001);
      mem_addr = BASE + 32'd8; mem_rstrb = 1'b1;
      @(posedge clk); #1;
      mem_rstrb = 1'b0;
      check("t6_rdata_hold", mem_rdata, 32'h4);
      wr(BASE, 32'h66, 4'b0010);
      check("t6_irq", {31'd0, tx_irq}, 32'd1);
      rd(BASE + 32'd4, v); check("t6_status_after", v, 32'h4);
      starts.delete();
      wait_cyc(cyc + FRAME + 10);
      check("t6_no_frames", 32'(starts.size()), 32'd0);

      // Reset in the middle of data bit 3 of 0xF0 (bit 3 = 0)
      send(8'hF0, 1'b0); wc = cyc;
      wait_cyc(wc + 19);
      check("t1_bit3_low", {31'd0, uart_txd}, 32'd0);
      check("t1_irq_busy", {31'd0, tx_irq}, 32'd0);
      RESET = 1'b1; #1;
      check("t1_txd_in_reset", {31'd0, uart_txd}, 32'd1);
      check("t1_rdata_in_reset", mem_rdata, 32'd0);
      check("t1_irq_in_reset", {31'd0, tx_irq}, 32'd1);
      repeat (2) @(posedge clk); #1;
      RESET = 1'b0;
      rd(BASE + 32'd4, v); check("t1_status_after", v, 32'h4);
      check("t1_irq_after", {31'd0, tx_irq}, 32'd1);
      starts.delete();
      wait_cyc(cyc + FRAME + 20);
      check("t1_no_resume", 32'(starts.size()), 32'd0);
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
